// File: rtl/sprite_pkg.sv
// Shared constants and types for the sprite blitter and its ROM bank.
// Sprite ids index the ROM bank; SONG ids need a bank wider than the default 8 sources.
package sprite_pkg;

  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;
  localparam int COLOUR_W = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } blit_state_t;

  localparam int SPR_BG     = 0;
  localparam int SPR_TEST   = 1;
  localparam int SPR_RED    = 2;
  localparam int SPR_PINK   = 3;
  localparam int SPR_BLUE   = 4;
  localparam int SPR_YELLOW = 5;
  localparam int SPR_TARGET = 6;
  localparam int SPR_SONG1  = 7;
  localparam int SPR_SONG2  = 8;
  localparam int SPR_SONG3  = 9;

  localparam logic [11:0] KEY_WHITE = 12'hFFF;
  localparam logic [11:0] KEY_DARK  = 12'h111;

  typedef struct packed {
    logic [8:0] w;
    logic [7:0] h;
  } sprite_size_t;

  // Size lookup so callers issue commands without hard-coded per-sprite cases.
  function automatic sprite_size_t sprite_size(input int id);
    sprite_size_t s;
    case (id)
      SPR_BG:     s = '{w: 9'd320, h: 8'd240};
      SPR_TEST:   s = '{w: 9'd16,  h: 8'd16};
      SPR_RED,
      SPR_PINK,
      SPR_BLUE,
      SPR_YELLOW: s = '{w: 9'd32,  h: 8'd32};
      SPR_TARGET: s = '{w: 9'd48,  h: 8'd48};
      SPR_SONG1,
      SPR_SONG2,
      SPR_SONG3:  s = '{w: 9'd160, h: 8'd40};
      default:    s = '{w: 9'd0,   h: 8'd0};
    endcase
    return s;
  endfunction

endpackage

// File: rtl/sprite_rom_mux.sv
// Fans the blitter's pixel address out to every sprite ROM and selects the
// active ROM's (already registered) output.
module sprite_rom_mux #(
  parameter int COLOUR_W    = sprite_pkg::COLOUR_W,
  parameter int ADDR_W      = 17,
  parameter int NUM_SPRITES = 8,
  parameter int SEL_W       = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
  input  logic [SEL_W-1:0]                      rom_sel,
  input  logic [ADDR_W-1:0]                     rom_addr,
  output logic [ADDR_W-1:0]                     bank_addr,
  input  logic [NUM_SPRITES-1:0][COLOUR_W-1:0]  bank_q,
  output logic [COLOUR_W-1:0]                   rom_data
);
  import sprite_pkg::*;

  assign bank_addr = rom_addr;

  // Select the requested ROM; an out-of-range select reads as zero.
  always_comb begin
    rom_data = {COLOUR_W{1'b0}};
    for (int i = 0; i < NUM_SPRITES; i++) begin
      rom_data = (rom_sel == SEL_W'(i)) ? bank_q[i] : rom_data;
    end
  end

endmodule

// File: rtl/sprite_blitter.sv
// Raster-order rectangle blitter: walks a sprite or solid fill command one pixel
// per cycle and emits clipped, colour-keyed plot strobes to vga_adapter.
module sprite_blitter #(
  parameter int X_W         = 9,
  parameter int Y_W         = 8,
  parameter int COLOUR_W    = sprite_pkg::COLOUR_W,
  parameter int ADDR_W      = 17,
  parameter int NUM_SPRITES = 8,
  parameter int SCREEN_W    = sprite_pkg::SCREEN_W,
  parameter int SCREEN_H    = sprite_pkg::SCREEN_H,
  parameter int SEL_W       = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_fill,
  input  logic                cmd_key_en,
  input  logic [COLOUR_W-1:0] cmd_key,
  input  logic [SEL_W-1:0]    cmd_sel,
  input  logic [X_W-1:0]      cmd_x,
  input  logic [Y_W-1:0]      cmd_y,
  input  logic [X_W-1:0]      cmd_w,
  input  logic [Y_W-1:0]      cmd_h,
  input  logic [COLOUR_W-1:0] cmd_colour,
  output logic [SEL_W-1:0]    rom_sel,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [COLOUR_W-1:0] rom_data,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot,
  output logic                busy,
  output logic                done
);
  import sprite_pkg::*;

  localparam logic [X_W:0] X_LIM = (X_W + 1)'(SCREEN_W);
  localparam logic [Y_W:0] Y_LIM = (Y_W + 1)'(SCREEN_H);

  blit_state_t         state_r;
  logic                cmd_ready_r;
  logic                busy_r;
  logic                done_r;
  logic                drain_r;
  logic                fill_r;
  logic                key_en_r;
  logic [COLOUR_W-1:0] key_r;
  logic [SEL_W-1:0]    sel_r;
  logic [X_W-1:0]      x_r;
  logic [Y_W-1:0]      y_r;
  logic [X_W-1:0]      w_r;
  logic [Y_W-1:0]      h_r;
  logic [COLOUR_W-1:0] colour_r;
  logic [X_W-1:0]      col_r;
  logic [Y_W-1:0]      row_r;
  logic [ADDR_W-1:0]   rom_addr_r;

  logic                s2_valid_r;
  logic [X_W:0]        s2_x_r;
  logic [Y_W:0]        s2_y_r;

  logic [X_W-1:0]      vga_x_r;
  logic [Y_W-1:0]      vga_y_r;
  logic [COLOUR_W-1:0] vga_colour_r;
  logic                vga_plot_r;

  logic                col_last_s;
  logic                row_last_s;
  logic                clip_s;
  logic                key_hit_s;

  assign col_last_s = (col_r == (w_r - X_W'(1)));
  assign row_last_s = (row_r == (h_r - Y_W'(1)));
  assign clip_s     = (s2_x_r >= X_LIM) || (s2_y_r >= Y_LIM);
  assign key_hit_s  = key_en_r && !fill_r && (rom_data == key_r);

  // Command FSM and stage-1 pixel walker (rom_addr, col, row).
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_r     <= IDLE;
      cmd_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      drain_r     <= 1'b0;
      fill_r      <= 1'b0;
      key_en_r    <= 1'b0;
      key_r       <= {COLOUR_W{1'b0}};
      sel_r       <= {SEL_W{1'b0}};
      x_r         <= {X_W{1'b0}};
      y_r         <= {Y_W{1'b0}};
      w_r         <= {X_W{1'b0}};
      h_r         <= {Y_W{1'b0}};
      colour_r    <= {COLOUR_W{1'b0}};
      col_r       <= {X_W{1'b0}};
      row_r       <= {Y_W{1'b0}};
      rom_addr_r  <= {ADDR_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (cmd_valid && cmd_ready_r) begin
            fill_r      <= cmd_fill;
            key_en_r    <= cmd_key_en;
            key_r       <= cmd_key;
            sel_r       <= cmd_sel;
            x_r         <= cmd_x;
            y_r         <= cmd_y;
            w_r         <= cmd_w;
            h_r         <= cmd_h;
            colour_r    <= cmd_colour;
            col_r       <= {X_W{1'b0}};
            row_r       <= {Y_W{1'b0}};
            rom_addr_r  <= {ADDR_W{1'b0}};
            cmd_ready_r <= 1'b0;
            busy_r      <= 1'b1;
            if ((cmd_w == {X_W{1'b0}}) || (cmd_h == {Y_W{1'b0}})) begin
              state_r <= DONE;
              done_r  <= 1'b1;
            end else begin
              state_r <= RUN;
            end
          end
        end
        RUN: begin
          if (col_last_s && row_last_s) begin
            state_r <= DRAIN;
            drain_r <= 1'b0;
          end else begin
            rom_addr_r <= rom_addr_r + ADDR_W'(1);
            if (col_last_s) begin
              col_r <= {X_W{1'b0}};
              row_r <= row_r + Y_W'(1);
            end else begin
              col_r <= col_r + X_W'(1);
            end
          end
        end
        // Two cycles let the last pixel clear the ROM and output stages.
        DRAIN: begin
          if (drain_r) begin
            state_r <= DONE;
            done_r  <= 1'b1;
          end else begin
            drain_r <= 1'b1;
          end
        end
        DONE: begin
          state_r     <= IDLE;
          done_r      <= 1'b0;
          cmd_ready_r <= 1'b1;
          busy_r      <= 1'b0;
        end
        default: begin
          state_r     <= IDLE;
          done_r      <= 1'b0;
          cmd_ready_r <= 1'b1;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  // Stage 2: screen coordinates, aligned with rom_data arriving from the ROM.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      s2_valid_r <= 1'b0;
      s2_x_r     <= {(X_W + 1){1'b0}};
      s2_y_r     <= {(Y_W + 1){1'b0}};
    end else begin
      s2_valid_r <= (state_r == RUN);
      s2_x_r     <= {1'b0, x_r} + {1'b0, col_r};
      s2_y_r     <= {1'b0, y_r} + {1'b0, row_r};
    end
  end

  // Output stage: clipping and transparency only suppress the strobe.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      vga_x_r      <= {X_W{1'b0}};
      vga_y_r      <= {Y_W{1'b0}};
      vga_colour_r <= {COLOUR_W{1'b0}};
      vga_plot_r   <= 1'b0;
    end else if (s2_valid_r) begin
      vga_x_r      <= s2_x_r[X_W-1:0];
      vga_y_r      <= s2_y_r[Y_W-1:0];
      vga_colour_r <= fill_r ? colour_r : rom_data;
      vga_plot_r   <= !clip_s && !key_hit_s;
    end else begin
      vga_plot_r   <= 1'b0;
    end
  end

  assign cmd_ready  = cmd_ready_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign rom_sel    = sel_r;
  assign rom_addr   = rom_addr_r;
  assign vga_x      = vga_x_r;
  assign vga_y      = vga_y_r;
  assign vga_colour = vga_colour_r;
  assign vga_plot   = vga_plot_r;

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter driving a modelled ROM bank through sprite_rom_mux.
module tb_sprite_blitter;
  import sprite_pkg::*;

  localparam int X_W = 9;
  localparam int Y_W = 8;
  localparam int CW  = 12;
  localparam int AW  = 17;
  localparam int NS  = 8;
  localparam int SW  = 3;

  logic          CLOCK_50 = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_fill = 1'b0;
  logic          cmd_key_en = 1'b0;
  logic [CW-1:0] cmd_key = '0;
  logic [SW-1:0] cmd_sel = '0;
  logic [X_W-1:0] cmd_x = '0;
  logic [Y_W-1:0] cmd_y = '0;
  logic [X_W-1:0] cmd_w = '0;
  logic [Y_W-1:0] cmd_h = '0;
  logic [CW-1:0] cmd_colour = '0;
  logic [SW-1:0] rom_sel;
  logic [AW-1:0] rom_addr;
  logic [AW-1:0] bank_addr;
  logic [NS-1:0][CW-1:0] bank_q = '0;
  logic [CW-1:0] rom_data;
  logic [X_W-1:0] vga_x;
  logic [Y_W-1:0] vga_y;
  logic [CW-1:0] vga_colour;
  logic          vga_plot;
  logic          busy;
  logic          done;

  always #5 CLOCK_50 = ~CLOCK_50;

  sprite_blitter #(.X_W(X_W), .Y_W(Y_W), .COLOUR_W(CW), .ADDR_W(AW), .NUM_SPRITES(NS),
                   .SCREEN_W(320), .SCREEN_H(240)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_fill(cmd_fill), .cmd_key_en(cmd_key_en), .cmd_key(cmd_key), .cmd_sel(cmd_sel),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_colour(cmd_colour),
    .rom_sel(rom_sel), .rom_addr(rom_addr), .rom_data(rom_data), .vga_x(vga_x),
    .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot), .busy(busy), .done(done)
  );

  sprite_rom_mux #(.COLOUR_W(CW), .ADDR_W(AW), .NUM_SPRITES(NS)) u_rom_mux (
    .rom_sel(rom_sel), .rom_addr(rom_addr), .bank_addr(bank_addr),
    .bank_q(bank_q), .rom_data(rom_data)
  );

  // ROM contents: TEST returns its index, RED is FFF at even indices.
  function automatic logic [CW-1:0] rom_model(input int s, input logic [AW-1:0] a);
    case (s)
      SPR_TEST: return a[11:0];
      SPR_RED:  return a[0] ? (12'h100 + a[11:0]) : 12'hFFF;
      default:  return 12'hABC;
    endcase
  endfunction

  always @(posedge CLOCK_50) begin
    for (int s = 0; s < NS; s++) bank_q[s] <= rom_model(s, bank_addr);
  end

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  int px[$], py[$], pc[$], pt[$];
  int done_cnt = 0;
  logic [AW-1:0] addr_hist [0:4095];

  always @(negedge CLOCK_50) begin
    addr_hist[cyc % 4096] = rom_addr;
    if (vga_plot) begin
      px.push_back(int'(vga_x));
      py.push_back(int'(vga_y));
      pc.push_back(int'(vga_colour));
      pt.push_back(cyc);
    end
    if (done) done_cnt++;
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input int got, input int expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, expv, expv);
    end
  endtask

  task automatic clear_log();
    px.delete(); py.delete(); pc.delete(); pt.delete();
  endtask

  task automatic send(input logic fill, input logic key_en, input logic [CW-1:0] key,
                      input int sel, input int x, input int y, input int w, input int h,
                      input logic [CW-1:0] colour, input logic hold, output int acc);
    int n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge CLOCK_50);
      n++;
    end
    check("ready_before_cmd", int'(cmd_ready), 1);
    cmd_fill   = fill;
    cmd_key_en = key_en;
    cmd_key    = key;
    cmd_sel    = SW'(sel);
    cmd_x      = X_W'(x);
    cmd_y      = Y_W'(y);
    cmd_w      = X_W'(w);
    cmd_h      = Y_W'(h);
    cmd_colour = colour;
    cmd_valid  = 1'b1;
    acc        = cyc;
    @(negedge CLOCK_50);
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int dc);
    dc = -1;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        dc = cyc;
        break;
      end
      @(negedge CLOCK_50);
    end
  endtask

  int acc, dc, d0, np;
  int exp_x[6] = '{10, 11, 12, 10, 11, 12};
  int exp_y[6] = '{20, 20, 20, 21, 21, 21};

  initial begin
    repeat (3) @(negedge CLOCK_50);
    reset = 1'b0;
    @(negedge CLOCK_50);
    check("rst_ready", int'(cmd_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_plot", int'(vga_plot), 0);
    check("rst_addr", int'(rom_addr), 0);
    check("rst_xy", int'(vga_x) + int'(vga_y), 0);
    check("rst_colour", int'(vga_colour), 0);
    check("rst_sel", int'(rom_sel), 0);
    clear_log();

    // Fill 3x2 at (10,20).
    send(1'b1, 1'b0, 12'h000, 0, 10, 20, 3, 2, 12'h0FF, 1'b0, acc);
    check("fill_busy", int'(busy), 1);
    wait_done(50, dc);
    check("fill_done_cyc", dc, acc + 9);
    check("fill_count", px.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < px.size()) begin
        check("fill_x", px[i], exp_x[i]);
        check("fill_y", py[i], exp_y[i]);
        check("fill_colour", pc[i], 'h0FF);
        check("fill_cyc", pt[i], acc + 3 + i);
      end
    end
    repeat (3) @(negedge CLOCK_50);
    clear_log();

    // Sprite TEST 16x16 at (0,0), no key.
    send(1'b0, 1'b0, 12'h000, SPR_TEST, 0, 0, 16, 16, 12'h000, 1'b0, acc);
    check("spr_sel", int'(rom_sel), SPR_TEST);
    wait_done(400, dc);
    check("spr_done_cyc", dc, acc + 259);
    check("spr_count", px.size(), 256);
    for (int i = 0; i < 256; i++) begin
      if (i < px.size()) begin
        check("spr_colour", pc[i], i);
        check("spr_x", px[i], i % 16);
        check("spr_y", py[i], i / 16);
        check("spr_cyc", pt[i], acc + 3 + i);
        check("spr_addr_lead", int'(addr_hist[(pt[i] - 2) % 4096]), i);
      end
    end
    repeat (3) @(negedge CLOCK_50);
    clear_log();

    // Keyed 4x1 sprite: even pixels are FFF and transparent.
    send(1'b0, 1'b1, 12'hFFF, SPR_RED, 5, 6, 4, 1, 12'h000, 1'b0, acc);
    wait_done(50, dc);
    check("key_done_cyc", dc, acc + 7);
    check("key_count", px.size(), 2);
    if (px.size() >= 2) begin
      check("key_x0", px[0], 6);
      check("key_x1", px[1], 8);
      check("key_y", py[1], 6);
      check("key_c0", pc[0], 'h101);
      check("key_c1", pc[1], 'h103);
      check("key_cyc1", pt[1], acc + 6);
    end
    repeat (3) @(negedge CLOCK_50);
    clear_log();

    // Clipping at the bottom-right corner.
    send(1'b1, 1'b0, 12'h000, 0, 318, 239, 4, 2, 12'h0F0, 1'b0, acc);
    wait_done(50, dc);
    check("clip_done_cyc", dc, acc + 11);
    check("clip_count", px.size(), 2);
    if (px.size() >= 2) begin
      check("clip_x0", px[0], 318);
      check("clip_x1", px[1], 319);
      check("clip_y0", py[0], 239);
      check("clip_y1", py[1], 239);
    end
    repeat (3) @(negedge CLOCK_50);
    clear_log();

    // Zero-size command.
    send(1'b1, 1'b0, 12'h000, 0, 7, 7, 0, 5, 12'h00F, 1'b0, acc);
    wait_done(20, dc);
    check("zero_done_cyc", dc, acc + 1);
    repeat (5) @(negedge CLOCK_50);
    check("zero_count", px.size(), 0);
    clear_log();

    // cmd_valid held through a command; field changes after accept ignored.
    d0 = done_cnt;
    send(1'b1, 1'b0, 12'h000, 0, 50, 60, 2, 1, 12'h321, 1'b1, acc);
    cmd_x = 9'd70;
    cmd_y = 8'd10;
    wait_done(50, dc);
    cmd_valid = 1'b0;
    check("hold_done_cyc", dc, acc + 5);
    repeat (10) @(negedge CLOCK_50);
    check("hold_done_cnt", done_cnt, d0 + 1);
    check("hold_count", px.size(), 2);
    if (px.size() >= 2) begin
      check("hold_x0", px[0], 50);
      check("hold_x1", px[1], 51);
      check("hold_y", py[1], 60);
    end
    check("hold_idle", int'(cmd_ready), 1);
    clear_log();

    // Reset in the middle of a 32x32 fill.
    send(1'b1, 1'b0, 12'h000, 0, 0, 0, 32, 32, 12'hF00, 1'b0, acc);
    repeat (20) @(negedge CLOCK_50);
    d0 = done_cnt;
    reset = 1'b1;
    @(negedge CLOCK_50);
    check("rstmid_plot", int'(vga_plot), 0);
    check("rstmid_busy", int'(busy), 0);
    reset = 1'b0;
    np = px.size();
    check("rstmid_plots_before", np, 19);
    @(negedge CLOCK_50);
    check("rstmid_ready", int'(cmd_ready), 1);
    repeat (40) @(negedge CLOCK_50);
    check("rstmid_no_done", done_cnt, d0);
    check("rstmid_no_plots", px.size(), np);
    clear_log();
    send(1'b1, 1'b0, 12'h000, 0, 100, 100, 1, 1, 12'h0F0, 1'b0, acc);
    wait_done(20, dc);
    check("post_rst_done_cyc", dc, acc + 4);
    check("post_rst_count", px.size(), 1);
    if (px.size() >= 1) begin
      check("post_rst_xy", px[0] * 1000 + py[0], 100100);
      check("post_rst_cyc", pt[0], acc + 3);
    end
    repeat (3) @(negedge CLOCK_50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 500000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sprite_blitter.md
Name: sprite_blitter

Overview:
- Parametrised successor to the single-sprite VGA draw sequencer. Accepts draw commands (sprite or solid rectangle) over a valid/ready handshake and walks the rectangle raster-order.
- Fetches pixels from a synchronous sprite ROM bank and emits x/y/colour/plot to vga_adapter.
- Supports colour-key transparency, screen clipping, NUM_SPRITES selectable sources and per-command done signalling.
- Sits between the game/menu FSM and vga_adapter; replaces per-sprite hard-coded size cases.

Parameters:
- X_W, 9, x coordinate / width bits
- Y_W, 8, y coordinate / height bits
- COLOUR_W, 12, colour bits (4 per channel)
- ADDR_W, 17, sprite ROM address bits
- NUM_SPRITES, 8, number of ROM sources; SEL_W = clog2(NUM_SPRITES)
- SCREEN_W, 320, visible width
- SCREEN_H, 240, visible height

Ports:
- CLOCK_50  in  1  system clock
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  block idle, can accept
- cmd_fill  in  1  1 = solid fill with cmd_colour, 0 = sprite from ROM
- cmd_key_en  in  1  enable transparency key (sprite mode only)
- cmd_key  in  COLOUR_W  transparent colour value
- cmd_sel  in  SEL_W  sprite ROM select
- cmd_x / cmd_y  in  X_W / Y_W  top-left corner
- cmd_w / cmd_h  in  X_W / Y_W  rectangle size in pixels
- cmd_colour  in  COLOUR_W  fill colour
- rom_sel  out  SEL_W  selects ROM data mux
- rom_addr  out  ADDR_W  linear pixel index, row-major
- rom_data  in  COLOUR_W  ROM output, 1-cycle read latency
- vga_x / vga_y  out  X_W / Y_W  pixel coordinate
- vga_colour  out  COLOUR_W  pixel colour
- vga_plot  out  1  write strobe
- busy  out  1  command in progress
- done  out  1  one-cycle pulse at command completion

Behaviour:
- Reset: state IDLE; cmd_ready=1 the cycle after reset deasserts; all other outputs = 0.
- Reset mid-command aborts immediately: no further plots, no done pulse.
- FSM states:
  - IDLE: cmd_ready=1. Acceptance = cmd_valid & cmd_ready at a clock edge. All cmd_* fields latch on that edge; later changes are ignored. Next state RUN (DONE if cmd_w==0 or cmd_h==0).
  - RUN: one pixel index per cycle, k = 0..W*H-1; rom_addr = k (registered), col/row counters advance x-first. After index W*H-1, go to DRAIN.
  - DRAIN: 2 cycles to flush the pipeline, then DONE.
  - DONE: done=1 for one cycle, then IDLE.
- busy = ~cmd_ready.
- Pipeline: pixel k is presented on rom_addr in cycle t. vga_x/vga_y/vga_colour/vga_plot for pixel k are registered and valid in cycle t+2. vga_plot is a single-cycle strobe per pixel.
- Coordinates: vga_x = cmd_x + col; vga_y = cmd_y + row. Compute at X_W+1 / Y_W+1 bits.
- vga_plot = 0 for a pixel when any of these holds:
  - the sum >= SCREEN_W or >= SCREEN_H (clipped);
  - sprite mode, cmd_key_en=1 and rom_data == cmd_key.
  In both cases the ROM address still advances.
- Fill mode: vga_colour = cmd_colour; rom_data ignored; key ignored; rom_addr still counts.
- Sprite mode: vga_colour = rom_data; rom_sel = cmd_sel for the whole command.
- Timing: first RUN cycle is accept+1; done cycle is accept + W*H + 3. Zero-size command: done at accept+1, no plots.
- Max rectangle is SCREEN_W x SCREEN_H. The index counter is ADDR_W bits wide; W*H must be < 2^ADDR_W. Wrap beyond that is undefined and must not be issued.
- cmd_valid while busy: ignored; no queueing.

Decomposition:
- Shared package sprite_pkg:
  - screen constants SCREEN_W/SCREEN_H;
  - COLOUR_W;
  - FSM state enum (IDLE, RUN, DRAIN, DONE);
  - sprite id constants (BG, TEST, RED, PINK, BLUE, YELLOW, TARGET, SONG1-3) and their sizes;
  - default key values 12'hFFF and 12'h111.
- One sub-module: sprite_rom_mux, the NUM_SPRITES-way ROM instance bank with rom_sel mux. It is kept outside sprite_blitter so the blitter stays ROM-agnostic.

Test Plan:
- Fill mode, x=10, y=20, w=3, h=2, colour=12'h0FF:
  - exactly 6 plots at (10,20)(11,20)(12,20)(10,21)(11,21)(12,21), all colour 0FF;
  - done at accept+9.
- Sprite mode, sel=TEST, 16x16 at (0,0), key disabled, ROM returns addr[11:0]:
  - 256 plots, colour == index of each pixel;
  - rom_addr leads vga_plot by 2 cycles.
- Sprite mode, key_en=1, key=FFF, ROM returns FFF at even indices, 4x1 sprite:
  - plots only pixels 1 and 3;
  - done still at accept+7.
- Clipping, fill at x=318, y=239, w=4, h=2: exactly 2 plots, at (318,239) and (319,239).
- Assert reset during RUN of a 32x32 command:
  - the next cycle has vga_plot=0 and busy=0, and no done pulse follows;
  - cmd_ready=1 after reset release, and a new 1x1 command completes normally.
- Zero size, w=0, h=5: no plots, done at accept+1. A cmd_valid held during busy produces no second command.
